// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: FSM state encoding and datapath widths.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_MEM  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_arbiter_mem_to_reg_mux.sv
// Memory-to-register writeback mux: picks load data or ALU result for the register file.
module wb_arbiter_mem_to_reg_mux
  import wb_arbiter_pkg::*;
(
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] write_data
);

  assign write_data = mem_to_reg ? mem_data : alu_data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter between ALU results and load data, one register-file write per cycle.
// Optional memory-streak guard enabled by defining WB_STREAK_GUARD_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  MemtoReg,
  output logic [DATA_W-1:0]     WriteData
);

  if (MEM_STREAK_MAX < 1 || MEM_STREAK_MAX > 15) begin : g_bad_streak_max
    $error("wb_arbiter: MEM_STREAK_MAX must be in 1..15");
  end

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0]     alu_data_q, alu_data_d;
  logic [DATA_W-1:0]     mem_data_q, mem_data_d;
  logic                  guard_force;

`ifdef WB_STREAK_GUARD_EN
  localparam logic [3:0] STREAK_LIMIT = 4'(MEM_STREAK_MAX);

  logic [3:0] streak_q, streak_d;

  assign guard_force = alu_valid && (streak_q == STREAK_LIMIT);

  // Counts memory grants taken while the ALU is kept waiting; anything else restarts it.
  always_comb begin
    streak_d = '0;
    if (alu_valid && mem_ready) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign guard_force = 1'b0;
`endif

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset) begin
      mem_ready = mem_valid && !guard_force;
      alu_ready = alu_valid && !mem_ready;
    end
  end

  always_comb begin
    state_d      = ST_IDLE;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_data_d   = alu_data_q;
    mem_data_d   = mem_data_q;
    if (mem_ready) begin
      state_d      = ST_MEM;
      write_reg_d  = mem_rd;
      mem_to_reg_d = 1'b1;
      mem_data_d   = mem_data;
    end else if (alu_ready) begin
      state_d      = ST_ALU;
      write_reg_d  = alu_rd;
      mem_to_reg_d = 1'b0;
      alu_data_d   = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      alu_data_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_data_q   <= alu_data_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // A non-IDLE state means last cycle transferred; writes to r0 are swallowed here.
  assign RegWrite = (state_q != ST_IDLE) && (write_reg_q != '0);
  assign WriteReg = write_reg_q;
  assign MemtoReg = mem_to_reg_q;

  wb_arbiter_mem_to_reg_mux u_wb_mux (
    .mem_to_reg (mem_to_reg_q),
    .alu_data   (alu_data_q),
    .mem_data   (mem_data_q),
    .write_data (WriteData)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expected streak pattern follows WB_STREAK_GUARD_EN.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic        MemtoReg;
  logic [31:0] WriteData;

  int check_count = 0;
  int error_count = 0;

  wb_arbiter #(.MEM_STREAK_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .MemtoReg   (MemtoReg),
    .WriteData  (WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    alu_valid  = av;
    alu_rd     = ard;
    alu_result = ares;
    mem_valid  = mv;
    mem_rd     = mrd;
    mem_data   = mdat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic exp_mem;

    reset = 1'b1;
    applyStimulus(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd6, 32'h0000_0066);
    checkOutput("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    checkOutput("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    tick();
    checkOutput("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("rst_writereg", {27'd0, WriteReg}, 32'd0);
    checkOutput("rst_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("rst_writedata", WriteData, 32'd0);

    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    checkOutput("alu_only_alu_ready", {31'd0, alu_ready}, 32'd1);
    checkOutput("alu_only_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    checkOutput("alu_only_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("alu_only_writereg", {27'd0, WriteReg}, 32'd5);
    checkOutput("alu_only_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("alu_only_writedata", WriteData, 32'h0000_1234);

    applyStimulus(1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 5'd7, 32'hDEAD_BEEF);
    checkOutput("both_mem_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("both_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    checkOutput("both_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("both_memtoreg", {31'd0, MemtoReg}, 32'd1);
    checkOutput("both_writereg", {27'd0, WriteReg}, 32'd7);
    checkOutput("both_writedata", WriteData, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 5'd9, 32'h0000_9999, 1'b0, 5'd8, 32'h0000_8888);
    tick();
    checkOutput("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("idle_writereg_hold", {27'd0, WriteReg}, 32'd7);
    checkOutput("idle_memtoreg_hold", {31'd0, MemtoReg}, 32'd1);
    checkOutput("idle_writedata_hold", WriteData, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    checkOutput("rd0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    checkOutput("rd0_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("rd0_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("rd0_writedata", WriteData, 32'h0000_0055);

    // Both requesters held valid for ten cycles to expose the streak pattern.
    for (int i = 0; i < 10; i++) begin
`ifdef WB_STREAK_GUARD_EN
      exp_mem = ((i % 5) != 4);
`else
      exp_mem = 1'b1;
`endif
      applyStimulus(1'b1, 5'd3, 32'h0000_00A1 + i, 1'b1, 5'd9, 32'h0000_0100 + i);
      checkOutput($sformatf("streak_mem_ready_%0d", i), {31'd0, mem_ready}, {31'd0, exp_mem});
      checkOutput($sformatf("streak_alu_ready_%0d", i), {31'd0, alu_ready}, {31'd0, !exp_mem});
      tick();
      checkOutput($sformatf("streak_memtoreg_%0d", i), {31'd0, MemtoReg}, {31'd0, exp_mem});
      checkOutput($sformatf("streak_writedata_%0d", i), WriteData,
                  exp_mem ? (32'h0000_0100 + i) : (32'h0000_00A1 + i));
    end

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hCAFE_0000);
    tick();
    checkOutput("stream_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("stream_writedata", WriteData, 32'hCAFE_0000);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd12, 32'h0000_0012, 1'b1, 5'd11, 32'hCAFE_0001);
    checkOutput("midrst_alu_ready", {31'd0, alu_ready}, 32'd0);
    checkOutput("midrst_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    reset = 1'b0;
    checkOutput("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("midrst_writereg", {27'd0, WriteReg}, 32'd0);
    checkOutput("midrst_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("midrst_writedata", WriteData, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hCAFE_0002);
    tick();
    checkOutput("postrst_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("postrst_writedata", WriteData, 32'hCAFE_0002);

    applyStimulus(1'b1, 5'd1, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("alt0_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("alt0_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("alt0_writedata", WriteData, 32'h0000_0011);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0022);
    tick();
    checkOutput("alt1_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("alt1_memtoreg", {31'd0, MemtoReg}, 32'd1);
    checkOutput("alt1_writereg", {27'd0, WriteReg}, 32'd2);
    checkOutput("alt1_writedata", WriteData, 32'h0000_0022);
    applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("alt2_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("alt2_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("alt2_writedata", WriteData, 32'h0000_0033);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("final_idle_regwrite", {31'd0, RegWrite}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter MEM_STREAK_MAX, default 4: max consecutive memory grants while ALU waits (range 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result available for writeback.
REQ-005 alu_ready  output  1  ALU result accepted this cycle (combinational).
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_result  input  32  ALU result value.
REQ-008 mem_valid  input  1  load data available for writeback.
REQ-009 mem_ready  output  1  load data accepted this cycle (combinational).
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load data value.
REQ-012 RegWrite  output  1  register-file write enable (registered).
REQ-013 WriteReg  output  5  register-file write address (registered).
REQ-014 MemtoReg  output  1  writeback source select, 1 = memory, 0 = ALU (registered).
REQ-015 WriteData  output  32  selected writeback data (registered).

Function
REQ-016 Transfer occurs on a requester when valid and ready are both high on a rising edge; at most one transfer per cycle.
REQ-017 Ready SHALL depend only on valids and internal state; ready never asserted without its own valid.
REQ-018 FSM states: IDLE (no grant last cycle), ALU (ALU granted last cycle), MEM (memory granted last cycle); next state = source granted this cycle, IDLE if none.
REQ-019 Default priority: memory wins when both valid, unless the streak guard forces ALU.
REQ-020 Streak counter (4 bits) increments on each memory grant while alu_valid high; clears on any ALU grant or any cycle alu_valid low.
REQ-021 Guard: when counter equals MEM_STREAK_MAX and alu_valid high, ALU is granted and mem_ready held low that cycle.
REQ-022 Single valid: that requester is granted immediately, regardless of state.
REQ-023 Latency: granted data appears on WriteData/WriteReg/MemtoReg/RegWrite exactly one cycle after transfer.
REQ-024 WriteData = mem_data when MemtoReg=1, else alu_result; 32-bit, no extension or modification.
REQ-025 RegWrite = 1 only for a transfer with rd != 0; rd = 0 transfers are accepted (ready high) but produce RegWrite = 0.
REQ-026 Cycle with no transfer: RegWrite = 0; WriteReg, WriteData, MemtoReg hold previous values.
REQ-027 Back-to-back transfers sustained at one per cycle; no bubble on source switch.

Reset
REQ-028 While reset high: alu_ready = mem_ready = 0, no transfer occurs, regardless of valids.
REQ-029 After reset: state IDLE, streak counter 0, RegWrite 0, WriteReg 0, MemtoReg 0, WriteData 0.
REQ-030 Reset asserted mid-stream discards the pending registered write (RegWrite 0 next cycle).

Configuration
REQ-031 Macro WB_STREAK_GUARD_EN: defined -> REQ-020/REQ-021 active; undefined -> strict memory priority, counter absent, MEM_STREAK_MAX ignored.

Structure
REQ-032 Shared package holds FSM state encoding (IDLE/ALU/MEM), register-address width 5, data width 32.
REQ-033 Output select SHALL reuse the existing memory-to-register writeback mux as the single sub-module, fed by grant-registered data.

Verification
REQ-034 alu_valid=1, alu_rd=5, alu_result=0x0000_1234 alone -> alu_ready=1; next cycle RegWrite=1, WriteReg=5, MemtoReg=0, WriteData=0x0000_1234.
REQ-035 Both valid, mem_rd=7, mem_data=0xDEAD_BEEF -> mem_ready=1, alu_ready=0; next cycle MemtoReg=1, WriteReg=7, WriteData=0xDEAD_BEEF.
REQ-036 Guard enabled, MEM_STREAK_MAX=4, both valid continuously -> grants MEM,MEM,MEM,MEM,ALU, repeating; without macro ALU never granted.
REQ-037 alu_rd=0 transfer -> alu_ready=1, next cycle RegWrite=0.
REQ-038 Reset pulsed one cycle during continuous mem stream -> both ready 0 that cycle, RegWrite 0 next cycle, outputs zero, state IDLE.
REQ-039 Alternating single valids ALU,MEM,ALU on consecutive cycles -> three writes on consecutive cycles, MemtoReg 0,1,0.
